// File: rtl/cs_address_sequencer_pkg.sv
// Shared widths, COND encodings and flag bit positions for the control-store
// address sequencer.
package cs_address_sequencer_pkg;
   localparam int DATAWIDTH_JUMPADDRESS = 11;
   localparam int DATAWIDTH_CONDITION   = 3;
   localparam int DATAWIDTH_IR          = 32;
   localparam int DATAWIDTH_FLAGS       = 4;

   typedef enum logic [DATAWIDTH_CONDITION-1:0] {
      COND_NEXT   = 3'd0,
      COND_N      = 3'd1,
      COND_Z      = 3'd2,
      COND_V      = 3'd3,
      COND_C      = 3'd4,
      COND_IR13   = 3'd5,
      COND_JUMP   = 3'd6,
      COND_DECODE = 3'd7
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   localparam logic [DATAWIDTH_JUMPADDRESS-1:0] CS_RESET_ADDR = '0;
endpackage

// File: rtl/cs_address_sequencer_if.sv
// Microword/memory inputs and CSAR/flag/stall outputs of the sequencer.
interface cs_address_sequencer_if;
   import cs_address_sequencer_pkg::*;

   logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus;
   logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
   logic [DATAWIDTH_IR-1:0]          CS_ADDRESS_SEQUENCER_IR_InBus;
   logic [DATAWIDTH_FLAGS-1:0]       CS_ADDRESS_SEQUENCER_ALUFlags_InBus;
   logic                             CS_ADDRESS_SEQUENCER_FlagsLoad_In;
   logic                             CS_ADDRESS_SEQUENCER_MemRequest_In;
   logic                             CS_ADDRESS_SEQUENCER_MemReady_In;
   logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus;
   logic [DATAWIDTH_FLAGS-1:0]       CS_ADDRESS_SEQUENCER_Flags_OutBus;
   logic                             CS_ADDRESS_SEQUENCER_Stall_Out;

   modport master (
      output CS_ADDRESS_SEQUENCER_Condition_InBus, CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
             CS_ADDRESS_SEQUENCER_IR_InBus, CS_ADDRESS_SEQUENCER_ALUFlags_InBus,
             CS_ADDRESS_SEQUENCER_FlagsLoad_In, CS_ADDRESS_SEQUENCER_MemRequest_In,
             CS_ADDRESS_SEQUENCER_MemReady_In,
      input  CS_ADDRESS_SEQUENCER_CSAddress_OutBus, CS_ADDRESS_SEQUENCER_Flags_OutBus,
             CS_ADDRESS_SEQUENCER_Stall_Out
   );

   modport slave (
      input  CS_ADDRESS_SEQUENCER_Condition_InBus, CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
             CS_ADDRESS_SEQUENCER_IR_InBus, CS_ADDRESS_SEQUENCER_ALUFlags_InBus,
             CS_ADDRESS_SEQUENCER_FlagsLoad_In, CS_ADDRESS_SEQUENCER_MemRequest_In,
             CS_ADDRESS_SEQUENCER_MemReady_In,
      output CS_ADDRESS_SEQUENCER_CSAddress_OutBus, CS_ADDRESS_SEQUENCER_Flags_OutBus,
             CS_ADDRESS_SEQUENCER_Stall_Out
   );
endinterface

// File: rtl/cs_address_sequencer_next_address_logic.sv
// Combinational next-address select: increment, conditional/unconditional
// jump, or opcode decode into the upper half of the control store.
module cs_next_address_logic
   import cs_address_sequencer_pkg::*;
(
   input  logic [DATAWIDTH_CONDITION-1:0]   cond,
   input  logic [DATAWIDTH_JUMPADDRESS-1:0] jump,
   input  logic [DATAWIDTH_IR-1:0]          ir,
   input  logic [DATAWIDTH_FLAGS-1:0]       flags,
   input  logic [DATAWIDTH_JUMPADDRESS-1:0] csar,
   output logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr
);
   logic [DATAWIDTH_JUMPADDRESS-1:0] incr;
   logic [DATAWIDTH_JUMPADDRESS-1:0] decode;
   logic                             take;
   logic                             unused_ir;

   // Increment wraps naturally at the 11-bit width.
   assign incr      = csar + 1'b1;
   assign decode    = {1'b1, ir[31:30], ir[24:19], 2'b00};
   assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};

   always_comb begin
      take      = 1'b0;
      next_addr = incr;
      unique case (cond_e'(cond))
         COND_NEXT:   take = 1'b0;
         COND_N:      take = flags[FLAG_N];
         COND_Z:      take = flags[FLAG_Z];
         COND_V:      take = flags[FLAG_V];
         COND_C:      take = flags[FLAG_C];
         COND_IR13:   take = ir[13];
         COND_JUMP:   take = 1'b1;
         COND_DECODE: take = 1'b0;
      endcase
      if (cond_e'(cond) == COND_DECODE)
         next_addr = decode;
      else if (take)
         next_addr = jump;
   end
endmodule

// File: rtl/cs_address_sequencer.sv
// Holds CSAR and the PSR flags; both freeze while a memory access is pending.
module cs_address_sequencer
   import cs_address_sequencer_pkg::*;
(
   input  logic                 CS_ADDRESS_SEQUENCER_CLOCK_50,
   input  logic                 CS_ADDRESS_SEQUENCER_ResetInHigh_In,
   cs_address_sequencer_if.slave bus
);
   logic [DATAWIDTH_JUMPADDRESS-1:0] csar;
   logic [DATAWIDTH_FLAGS-1:0]       flags;
   logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr;
   logic                             stall;

   assign stall = bus.CS_ADDRESS_SEQUENCER_MemRequest_In & ~bus.CS_ADDRESS_SEQUENCER_MemReady_In;

   cs_next_address_logic u_next (
      .cond      (bus.CS_ADDRESS_SEQUENCER_Condition_InBus),
      .jump      (bus.CS_ADDRESS_SEQUENCER_JumpAddress_InBus),
      .ir        (bus.CS_ADDRESS_SEQUENCER_IR_InBus),
      .flags     (flags),
      .csar      (csar),
      .next_addr (next_addr)
   );

   // Branches test the registered flags, so a same-word FlagsLoad is seen next word.
   always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50 or posedge CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
      if (CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
         csar  <= CS_RESET_ADDR;
         flags <= '0;
      end else if (!stall) begin
         csar <= next_addr;
         if (bus.CS_ADDRESS_SEQUENCER_FlagsLoad_In)
            flags <= bus.CS_ADDRESS_SEQUENCER_ALUFlags_InBus;
      end
   end

   assign bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus = csar;
   assign bus.CS_ADDRESS_SEQUENCER_Flags_OutBus     = flags;
   assign bus.CS_ADDRESS_SEQUENCER_Stall_Out        = stall;
endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed plus random microword stream checked against an arithmetic model
// of the sequencer.
module tb_cs_address_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   m_csar = 0;
   int   m_flags = 0;

   cs_address_sequencer_if bus ();

   cs_address_sequencer dut (
      .CS_ADDRESS_SEQUENCER_CLOCK_50      (clk),
      .CS_ADDRESS_SEQUENCER_ResetInHigh_In(rst),
      .bus                                (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int cond, input int jump, input logic [31:0] ir,
                        input int alu, input bit fl, input bit mreq, input bit mrdy);
      bus.CS_ADDRESS_SEQUENCER_Condition_InBus   = 3'(cond);
      bus.CS_ADDRESS_SEQUENCER_JumpAddress_InBus = 11'(jump);
      bus.CS_ADDRESS_SEQUENCER_IR_InBus          = ir;
      bus.CS_ADDRESS_SEQUENCER_ALUFlags_InBus    = 4'(alu);
      bus.CS_ADDRESS_SEQUENCER_FlagsLoad_In      = fl;
      bus.CS_ADDRESS_SEQUENCER_MemRequest_In     = mreq;
      bus.CS_ADDRESS_SEQUENCER_MemReady_In       = mrdy;
   endtask

   // Reference next address straight from the COND table.
   function automatic int model_next(input int cond, input int jump, input logic [31:0] ir);
      logic [31:0] v;
      int op, op3;
      v   = ir;
      op  = int'(v[31:30]);
      op3 = int'(v[24:19]);
      case (cond)
         0:          return (m_csar + 1) % 2048;
         1, 2, 3, 4: return ((m_flags >> (4 - cond)) & 1) ? jump : (m_csar + 1) % 2048;
         5:          return v[13] ? jump : (m_csar + 1) % 2048;
         6:          return jump;
         default:    return 1024 + op * 256 + op3 * 4;
      endcase
   endfunction

   // One microword: check stall, clock it, check CSAR and flags against model.
   task automatic step(input int cond, input int jump, input logic [31:0] ir,
                       input int alu, input bit fl, input bit mreq, input bit mrdy);
      bit st;
      drive(cond, jump, ir, alu, fl, mreq, mrdy);
      st = mreq && !mrdy;
      #1;
      chk("stall", 32'(bus.CS_ADDRESS_SEQUENCER_Stall_Out), 32'(st));
      if (!st) begin
         m_csar = model_next(cond, jump, ir);
         if (fl) m_flags = alu;
      end
      @(posedge clk);
      #1;
      chk("csar", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 32'(m_csar));
      chk("flags", 32'(bus.CS_ADDRESS_SEQUENCER_Flags_OutBus), 32'(m_flags));
   endtask

   initial begin
      logic [31:0] ir_dec;
      ir_dec = 32'h8000_0000 | (32'h10 << 19);

      drive(0, 0, 0, 4'hF, 1, 1, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_csar", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 0);
      chk("rst_flags", 32'(bus.CS_ADDRESS_SEQUENCER_Flags_OutBus), 0);
      chk("rst_stall", 32'(bus.CS_ADDRESS_SEQUENCER_Stall_Out), 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1 rst = 1'b0;

      step(0, 5, 0, 0, 0, 0, 0);
      chk("incr_1", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 1);
      step(7, 5, ir_dec, 0, 0, 0, 0);
      chk("decode_1600", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 1600);

      step(6, 1584, 0, 0, 0, 0, 0);
      step(5, 1586, 32'h2000, 0, 0, 0, 0);
      chk("ir13_taken", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 1586);
      step(6, 1584, 0, 0, 0, 0, 0);
      step(5, 1586, 32'hFFFF_DFFF, 0, 0, 0, 0);
      chk("ir13_not", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 1585);

      step(2, 1700, 0, 4'b0100, 1, 0, 0);
      chk("z_old_flags", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 1586);
      step(2, 1700, 0, 0, 0, 0, 0);
      chk("z_new_flags", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 1700);

      step(6, 0, 0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 4'hA, 1, 1, 0);
      chk("stall_hold", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 0);
      step(0, 0, 0, 4'hA, 1, 1, 1);
      chk("stall_release", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 1);
      chk("stall_flags", 32'(bus.CS_ADDRESS_SEQUENCER_Flags_OutBus), 4'hA);
      chk("stall_low", 32'(bus.CS_ADDRESS_SEQUENCER_Stall_Out), 0);

      step(6, 2047, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("wrap", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 0);
      step(6, 1603, 0, 0, 0, 0, 0);
      chk("jump_uncond", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 1603);

      step(6, 1601, 0, 4'hF, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      #2 rst = 1'b1;
      #1;
      m_csar = 0;
      m_flags = 0;
      chk("async_rst_csar", 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 0);
      chk("async_rst_flags", 32'(bus.CS_ADDRESS_SEQUENCER_Flags_OutBus), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 300; i++) begin
         bit mreq;
         mreq = ($urandom_range(0, 9) < 3);
         step(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)), $urandom,
              int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), mreq,
              1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cs_address_sequencer.md
Name: cs_address_sequencer

Overview:
Microsequencer that produces the control-store address consumed by the microcode store. It holds the current CS address register (CSAR) and the PSR flag register (N,Z,V,C). Each cycle it selects the next address: increment, conditional or unconditional jump, or decode of the IR opcode. It stalls on an unfinished main-memory access.

Parameters:
DATAWIDTH_JUMPADDRESS, 11, CS address and jump-field width
DATAWIDTH_CONDITION, 3, MIR COND field width
DATAWIDTH_IR, 32, instruction register width
DATAWIDTH_FLAGS, 4, PSR flag bits {N,Z,V,C}

Ports:
CS_ADDRESS_SEQUENCER_CLOCK_50  in  1  system clock; CSAR and flags update on posedge
CS_ADDRESS_SEQUENCER_ResetInHigh_In  in  1  asynchronous reset, active-high
CS_ADDRESS_SEQUENCER_Condition_InBus  in  3  MIR COND field
CS_ADDRESS_SEQUENCER_JumpAddress_InBus  in  11  MIR JUMP ADDR field
CS_ADDRESS_SEQUENCER_IR_InBus  in  32  current instruction register
CS_ADDRESS_SEQUENCER_ALUFlags_InBus  in  4  {N,Z,V,C} from the ALU for the current microinstruction
CS_ADDRESS_SEQUENCER_FlagsLoad_In  in  1  latch ALU flags; driven high for cc-setting ALU ops
CS_ADDRESS_SEQUENCER_MemRequest_In  in  1  MIR RD or WR active this microinstruction
CS_ADDRESS_SEQUENCER_MemReady_In  in  1  main memory completes the access this cycle
CS_ADDRESS_SEQUENCER_CSAddress_OutBus  out  11  registered CSAR, drives microcode store address
CS_ADDRESS_SEQUENCER_Flags_OutBus  out  4  registered PSR flags {N,Z,V,C}
CS_ADDRESS_SEQUENCER_Stall_Out  out  1  combinational: MemRequest_In & ~MemReady_In

Behaviour:
- Reset (async, high): CSAR=0, flags=0000. Stall_Out follows its inputs.
- Reset release: first posedge computes the next address from microword 0.
- CSAR latency: one posedge. The microcode store samples CSAR on the following negedge, so MIR is valid half a cycle later.
- Next-address selection by COND:
  - 000: CSAR+1
  - 001: JUMP if N else CSAR+1
  - 010: JUMP if Z else CSAR+1
  - 011: JUMP if V else CSAR+1
  - 100: JUMP if C else CSAR+1
  - 101: JUMP if IR[13] else CSAR+1
  - 110: JUMP unconditionally
  - 111: decode address = {1'b1, IR[31:30], IR[24:19], 2'b00}. Example: op=10, op3=010000 gives 1600.
- Increment is modulo 2^11: 2047+1 wraps to 0 with no error flag.
- Flag tests use the registered flags only, never ALU_Flags_InBus directly.
- FlagsLoad and a flag test in the same microword: the branch uses the old flags; the new flags are visible from the next microword.
- Flag register: on posedge with FlagsLoad_In=1 and not stalled, flags <= ALUFlags_InBus; otherwise hold.
- Stall: while Stall_Out=1, CSAR and flags hold on every posedge. The same microword is re-presented until MemReady_In=1.
- Stall release: on the posedge where MemReady_In=1, CSAR advances normally, and FlagsLoad takes effect that cycle only.
- MemRequest_In=0: MemReady_In is ignored.
- Reset mid-stall or mid-branch: immediate return to CSAR=0 and flags=0. No pending state survives reset.
- Unknown or unused COND encodings do not exist: all 8 are defined.
- IR is sampled combinationally; the IR register owner keeps it stable across the decode cycle.

Decomposition:
- Shared package: COND encodings (COND_NEXT, COND_N, COND_Z, COND_V, COND_C, COND_IR13, COND_JUMP, COND_DECODE), flag bit indices (N=3, Z=2, V=1, C=0), CS_RESET_ADDR=0.
- Natural sub-module: cs_next_address_logic. It is pure combinational: COND, JUMP, IR, flags and CSAR go in; the next address comes out. The top level holds CSAR, the flag register and the stall gating.

Test Plan:
- Reset asserted mid-run with CSAR=1601 and flags=1111 -> CSAR=0 and flags=0000 immediately, without waiting for a clock edge.
- CSAR=0, COND=000, no stall -> CSAR=1 after one posedge; CSAR=1, COND=111, IR op=10 op3=010000 -> CSAR=1600 (11'b11001000000).
- CSAR=1584, COND=101, JUMP=1586: IR[13]=1 -> 1586; IR[13]=0 -> 1585.
- Flags=0000, FlagsLoad=1 with ALUFlags=0100 and COND=010, JUMP=1700 in the same microword -> CSAR=CSAR+1. Next microword with COND=010 -> 1700.
- CSAR=0, MemRequest=1, MemReady=0 for 3 cycles -> CSAR stays 0 and Stall_Out=1. MemReady=1 -> CSAR=1 on that posedge and Stall_Out=0.
- CSAR=2047, COND=000 -> CSAR=0. COND=110, JUMP=1603 -> CSAR=1603 regardless of flags.
